// File: rtl/spi_master_if.sv
// ----------------------------------------------------------------------------
// spi_master_if
// Groups the host-side handshake and the SPI pins of spi_master.
//   start_i    host -> master  transfer request
//   tx_data_i  host -> master  byte to shift out on MOSI
//   SPI_MODE_i host -> master  {CPOL, CPHA}
//   busy_o     master -> host  transfer in progress
//   done_o     master -> host  one-cycle end-of-transfer pulse
//   rx_data_o  master -> host  byte assembled from MISO
//   SPI_Clk_o  master -> slave SPI clock
//   MOSI_o     master -> slave serial data out
//   CS_o       master -> slave chip select, active-high
//   MISO_i     slave -> master serial data in
// Modport master is used by spi_master; modport slave is its counterpart.
// ----------------------------------------------------------------------------
interface spi_master_if;
    logic       start_i;
    logic [7:0] tx_data_i;
    logic [1:0] SPI_MODE_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rx_data_o;
    logic       SPI_Clk_o;
    logic       MOSI_o;
    logic       CS_o;
    logic       MISO_i;

    modport master (
        input  start_i, tx_data_i, SPI_MODE_i, MISO_i,
        output busy_o, done_o, rx_data_o, SPI_Clk_o, MOSI_o, CS_o
    );

    modport slave (
        output start_i, tx_data_i, SPI_MODE_i, MISO_i,
        input  busy_o, done_o, rx_data_o, SPI_Clk_o, MOSI_o, CS_o
    );
endinterface

// File: rtl/spi_master.sv
// ----------------------------------------------------------------------------
// spi_master
// Single-byte SPI master, all four modes, SPI half-period of CLK_DIV cycles.
// Ports:
//   Clk_i    system clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      spi_master_if.master (handshake + SPI pins, see interface)
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | CS low, SPI_Clk_o follows CPOL input, waiting for start_i
// ST_SETUP    | CS high, one half-period before the first SPI clock edge
// ST_TRANSFER | 16 SPI clock edges, shifting MOSI and sampling MISO
// ST_HOLD     | half-period after edge 16, then one done/CS-low cycle
// ----------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         Clk_i,
    input  logic         rst_n_i,
    spi_master_if.master bus
);
    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_TRANSFER,
        ST_HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       edge_cnt;
    logic [4:0]       edge_nxt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [7:0]       rx_data_q;
    logic             cpha_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             done_q;

    logic             div_tc;
    logic             edge_emit;
    logic             edge_odd;
    logic             do_shift;
    logic             do_sample;
    logic             fin;

    assign div_tc    = (div_cnt == '0);
    assign edge_nxt  = edge_cnt + 5'd1;
    assign edge_odd  = edge_nxt[0];
    // Edge 1 leaves SETUP, edges 2..16 are emitted inside TRANSFER.
    assign edge_emit = ((state == ST_SETUP) || (state == ST_TRANSFER)) && div_tc;
    // CPHA=0 samples on odd edges, CPHA=1 on even edges.
    assign do_sample = edge_emit && (edge_odd != cpha_q);
    // CPHA=0 has bit7 out before edge 1, so only 7 shifts (edges 2..14).
    assign do_shift  = edge_emit && (cpha_q ? edge_odd
                                            : (!edge_odd && (edge_nxt != 5'd16)));
    // End of HOLD; done_q then marks the final HOLD cycle.
    assign fin       = (state == ST_HOLD) && div_tc && !done_q;

    always_ff @(posedge Clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.start_i) state_nxt = ST_SETUP;
            ST_SETUP:    if (div_tc) state_nxt = ST_TRANSFER;
            ST_TRANSFER: if (div_tc && (edge_cnt == 5'd15)) state_nxt = ST_HOLD;
            ST_HOLD:     if (done_q) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data_q <= '0;
            cpha_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fin;
            if (state == ST_IDLE) begin
                sclk_q <= bus.SPI_MODE_i[1];
                if (bus.start_i) begin
                    cpha_q   <= bus.SPI_MODE_i[0];
                    div_cnt  <= DIV_LAST;
                    edge_cnt <= '0;
                    rx_sh    <= '0;
                    if (bus.SPI_MODE_i[0]) begin
                        tx_sh  <= bus.tx_data_i;
                        mosi_q <= 1'b0;
                    end else begin
                        tx_sh  <= {bus.tx_data_i[6:0], 1'b0};
                        mosi_q <= bus.tx_data_i[7];
                    end
                end
            end else begin
                div_cnt <= div_tc ? DIV_LAST : div_cnt - DIV_W'(1);
                if (edge_emit) begin
                    sclk_q   <= ~sclk_q;
                    edge_cnt <= edge_nxt;
                end
                if (do_shift) begin
                    mosi_q <= tx_sh[7];
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                end
                if (do_sample) begin
                    rx_sh <= {bus.MISO_i, rx_sh[7:1]};
                end
                if (fin) begin
                    rx_data_q <= rx_sh;
                    mosi_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.busy_o    = (state != ST_IDLE);
    assign bus.CS_o      = (state != ST_IDLE) && !done_q;
    assign bus.done_o    = done_q;
    assign bus.rx_data_o = rx_data_q;
    assign bus.SPI_Clk_o = sclk_q;
    assign bus.MOSI_o    = bus.CS_o && mosi_q;

endmodule
